// File: rtl/status_readback.sv
// status_readback: JTAG USER1 readback path, oversampling BSCAN pins in usbclk.
// Ports:
//   usbclk, reset                    system clock, synchronous active-high reset
//   sel, drck, capture, shift, update async BSCAN USER1 pins
//   tdo                               serial data to BSCAN TDO1 (LSB first)
//   status_data, status_valid         word and freshness bit to snapshot
//   status_ack                        1-cycle pulse: fresh data taken at capture
//   read_done                         1-cycle pulse at Update-DR after a capture
//   overrun                           sticky: host shifted more than LEN bits
module status_readback #(
    parameter int W    = 40,
    parameter int SEQW = 8
) (
    input  logic         usbclk,
    input  logic         reset,
    input  logic         sel,
    input  logic         drck,
    input  logic         capture,
    input  logic         shift,
    input  logic         update,
    output logic         tdo,
    input  logic [W-1:0] status_data,
    input  logic         status_valid,
    output logic         status_ack,
    output logic         read_done,
    output logic         overrun
);
    localparam int LEN = W + SEQW + 1;
    localparam int CW  = $clog2(LEN + 1);

    typedef enum logic [1:0] {IDLE, LOADED, SHIFTING, EXHAUSTED} state_t;

    state_t          r_state, w_state_nxt;
    logic [LEN-1:0]  r_sr;
    logic [CW-1:0]   r_bitcnt;
    logic [SEQW-1:0] r_seq;
    logic            r_sel_s1, r_shift_s1;
    logic            r_drck_s1, r_drck_s2, r_cap_s1, r_cap_s2, r_upd_s1, r_upd_s2;
    logic            r_cap_ev, r_shf_ev, r_upd_ev;
    logic            w_active;

    // sel and shift are only used as level qualifiers at the first stage, so
    // their second stage would never be read and is left out.
    always_ff @(posedge usbclk) begin
        r_sel_s1   <= sel;
        r_shift_s1 <= shift;
        r_drck_s1  <= drck;
        r_drck_s2  <= r_drck_s1;
        r_cap_s1   <= capture;
        r_cap_s2   <= r_cap_s1;
        r_upd_s1   <= update;
        r_upd_s2   <= r_upd_s1;
    end

    always_ff @(posedge usbclk) begin
        if (reset) begin
            r_cap_ev <= 1'b0;
            r_shf_ev <= 1'b0;
            r_upd_ev <= 1'b0;
        end else begin
            r_cap_ev <= r_sel_s1 & r_cap_s1 & ~r_cap_s2;
            r_shf_ev <= r_sel_s1 & r_shift_s1 & r_drck_s1 & ~r_drck_s2;
            r_upd_ev <= r_sel_s1 & r_upd_s1 & ~r_upd_s2;
        end
    end

    assign w_active = (r_state == LOADED) || (r_state == SHIFTING);

    always_comb begin
        w_state_nxt = r_state;
        if (r_cap_ev)
            w_state_nxt = LOADED;
        else if (r_shf_ev)
            w_state_nxt = w_active ? ((r_bitcnt > CW'(1)) ? SHIFTING : EXHAUSTED) : r_state;
        else if (r_upd_ev && r_state != IDLE)
            w_state_nxt = IDLE;
    end

    always_ff @(posedge usbclk) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge usbclk) begin
        if (reset) begin
            r_sr       <= '0;
            r_bitcnt   <= '0;
            r_seq      <= '0;
            status_ack <= 1'b0;
            read_done  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            status_ack <= 1'b0;
            read_done  <= 1'b0;
            if (r_cap_ev) begin
                r_sr       <= {r_seq, status_valid, status_data};
                r_bitcnt   <= CW'(LEN);
                r_seq      <= r_seq + SEQW'(1);
                status_ack <= status_valid;
                overrun    <= 1'b0;
            end else if (r_shf_ev) begin
                if (w_active) begin
                    r_sr     <= {1'b0, r_sr[LEN-1:1]};
                    r_bitcnt <= r_bitcnt - CW'(1);
                end else if (r_state == EXHAUSTED) begin
                    r_sr    <= '0;
                    overrun <= 1'b1;
                end
            end else if (r_upd_ev && r_state != IDLE) begin
                read_done <= 1'b1;
            end
        end
    end

    assign tdo = r_sr[0];
endmodule

// File: tb/tb_status_readback.sv
// tb_status_readback: directed vector bench for status_readback.
module tb_status_readback;
    localparam int W = 40, SEQW = 8, LEN = 49;

    logic usbclk = 0, reset = 1, sel = 0, drck = 0, capture = 0, shift = 0, update = 0;
    logic status_valid = 0;
    logic [W-1:0] status_data = '0;
    logic tdo, status_ack, read_done, overrun;

    int n_pass = 0, n_total = 0;
    int ack_cnt = 0, done_cnt = 0, ack_wide = 0, done_wide = 0;
    logic ack_q = 0, done_q = 0;

    status_readback #(.W(W), .SEQW(SEQW)) dut (
        .usbclk(usbclk), .reset(reset), .sel(sel), .drck(drck), .capture(capture),
        .shift(shift), .update(update), .tdo(tdo), .status_data(status_data),
        .status_valid(status_valid), .status_ack(status_ack), .read_done(read_done),
        .overrun(overrun)
    );

    always #5 usbclk = ~usbclk;

    always @(negedge usbclk) begin
        if (status_ack) ack_cnt++;
        if (read_done) done_cnt++;
        if (status_ack && ack_q) ack_wide++;
        if (read_done && done_q) done_wide++;
        ack_q = status_ack;
        done_q = read_done;
    end

    typedef struct {
        logic [W-1:0]   data;
        logic           valid;
        logic [LEN-1:0] exp_word;
        int             exp_ack;
    } vec_t;
    vec_t vecs[4];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge usbclk);
    endtask

    task automatic do_cap(input logic [W-1:0] d, input logic v);
        status_data = d;
        status_valid = v;
        capture = 1;
        wait_n(4);
        capture = 0;
        wait_n(4);
    endtask

    task automatic do_shift(input int n, output logic [63:0] w);
        w = '0;
        for (int i = 0; i < n; i++) begin
            w[i] = tdo;
            drck = 1;
            wait_n(4);
            drck = 0;
            wait_n(4);
        end
    endtask

    task automatic do_upd;
        update = 1;
        wait_n(4);
        update = 0;
        wait_n(4);
    endtask

    initial begin
        logic [63:0] w;
        int a0, d0;
        logic t0;
        vecs[0] = '{40'h12_3456_789A, 1'b1, {8'h00, 1'b1, 40'h12_3456_789A}, 1};
        vecs[1] = '{40'hFF_FFFF_FFFF, 1'b0, {8'h01, 1'b0, 40'hFF_FFFF_FFFF}, 0};
        vecs[2] = '{40'h00_0000_0001, 1'b1, {8'h02, 1'b1, 40'h00_0000_0001}, 1};
        vecs[3] = '{40'hA5_5A0F_F0C3, 1'b1, {8'h03, 1'b1, 40'hA5_5A0F_F0C3}, 1};

        wait_n(3);
        chk("reset_tdo", 64'(tdo), 0);
        chk("reset_ack", 64'(status_ack), 0);
        chk("reset_done", 64'(read_done), 0);
        chk("reset_overrun", 64'(overrun), 0);
        reset = 0;
        sel = 1;
        shift = 1;
        wait_n(4);

        for (int i = 0; i < 4; i++) begin
            a0 = ack_cnt;
            d0 = done_cnt;
            do_cap(vecs[i].data, vecs[i].valid);
            chk($sformatf("vec%0d_ack", i), 64'(ack_cnt - a0), 64'(vecs[i].exp_ack));
            do_shift(LEN, w);
            chk($sformatf("vec%0d_word", i), w, 64'(vecs[i].exp_word));
            chk($sformatf("vec%0d_overrun", i), 64'(overrun), 0);
            do_upd();
            chk($sformatf("vec%0d_done", i), 64'(done_cnt - d0), 1);
        end

        for (int i = 0; i < 251; i++) do_cap('0, 1'b0);
        do_cap('0, 1'b0);
        do_shift(LEN, w);
        chk("seq_ff", 64'(w[48:41]), 64'h FF);
        do_upd();
        do_cap('0, 1'b0);
        do_shift(LEN, w);
        chk("seq_wrap", 64'(w[48:41]), 64'h00);
        do_upd();

        do_cap(40'hF0_F0F0_F0F0, 1'b1);
        do_shift(60, w);
        chk("ovr_word", 64'(w[48:0]), 64'({8'h01, 1'b1, 40'hF0_F0F0_F0F0}));
        chk("ovr_tail", 64'(w[59:49]), 0);
        chk("ovr_flag", 64'(overrun), 1);
        chk("ovr_tdo", 64'(tdo), 0);
        do_cap(40'h00_0000_0001, 1'b1);
        chk("ovr_clear", 64'(overrun), 0);
        chk("ovr_recap_tdo", 64'(tdo), 1);
        do_upd();

        do_cap(40'h00_0000_0C00, 1'b1);
        do_shift(10, w);
        chk("upd10_tdo", 64'(tdo), 1);
        d0 = done_cnt;
        do_upd();
        chk("upd10_done", 64'(done_cnt - d0), 1);
        do_shift(5, w);
        chk("upd10_hold", 64'(tdo), 1);
        do_upd();
        chk("upd_idle_nodone", 64'(done_cnt - d0), 1);

        do_cap(40'hFF_FFFF_FFFF, 1'b1);
        do_shift(20, w);
        chk("rst_pre_tdo", 64'(tdo), 1);
        reset = 1;
        wait_n(2);
        reset = 0;
        wait_n(1);
        chk("rst_tdo", 64'(tdo), 0);
        chk("rst_overrun", 64'(overrun), 0);
        d0 = done_cnt;
        do_shift(5, w);
        chk("rst_shift_ignored", 64'(tdo), 0);
        do_upd();
        chk("rst_upd_ignored", 64'(done_cnt - d0), 0);
        do_cap(40'h00_0000_0003, 1'b0);
        do_shift(LEN, w);
        chk("rst_seq0_word", w, 64'({8'h00, 1'b0, 40'h00_0000_0003}));
        do_upd();

        do_cap(40'h00_0000_0002, 1'b1);
        chk("sel_pre_tdo", 64'(tdo), 0);
        sel = 0;
        wait_n(4);
        a0 = ack_cnt;
        d0 = done_cnt;
        do_shift(1, w);
        chk("sel0_shift", 64'(tdo), 0);
        do_cap(40'h00_0000_0005, 1'b1);
        chk("sel0_cap_tdo", 64'(tdo), 0);
        chk("sel0_cap_ack", 64'(ack_cnt - a0), 0);
        do_upd();
        chk("sel0_upd", 64'(done_cnt - d0), 0);
        sel = 1;
        wait_n(4);
        do_shift(1, w);
        chk("sel1_resume", 64'(tdo), 1);

        chk("ack_width", 64'(ack_wide), 0);
        chk("done_width", 64'(done_wide), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
